mm_axis_seq_ctrl: RTL and testbench

- Sequencer between the MM2S/S2MM AXI-Stream FIFOs and the matrix-multiply `top` core.
- Drains input beats and weight beats from the MM2S FIFO read sides into the core's input and weight BRAM write ports.
- Pulses the core start, waits for the core to finish, then streams the core's output BRAM into the S2MM FIFO with correct AXIS backpressure and tlast.
- Replaces the free-running count-based loader with a handshake-exact one.

---
 rtl/mm_axis_pkg.sv | 31 +++
 rtl/axis_skid2.sv | 63 ++++++
 rtl/mm_axis_seq_ctrl.sv | 155 +++++++++++++++
 tb/tb_mm_axis_seq_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_axis_pkg.sv
// Shared types and sizing helpers for the AXI-Stream matrix-multiply sequencer.
package mm_axis_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StCompute,
    StDrain
  } state_e;

  localparam int unsigned DefWidth     = 16;
  localparam int unsigned DefChunkSize = 4;
  localparam int unsigned DefNumCores  = 2;
  localparam int unsigned WeWidth      = 8;

  function automatic int unsigned beat_width(input int unsigned width,
                                             input int unsigned chunk,
                                             input int unsigned cores);
    return width * chunk * cores;
  endfunction

  // Beats needed to move a rows x cols word matrix, chunk*cores words per beat, rounded up.
  function automatic int unsigned num_elements(input int unsigned rows,
                                               input int unsigned cols,
                                               input int unsigned chunk,
                                               input int unsigned cores);
    return (rows * cols + chunk * cores - 1) / (chunk * cores);
  endfunction

endpackage

// File: rtl/axis_skid2.sv
// Two-entry valid/ready buffer; head entry always drives the output.
module axis_skid2 #(
  parameter int unsigned DataW = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_valid,
  input  logic [DataW-1:0] push_data,
  input  logic             pop_ready,
  output logic             pop_valid,
  output logic [DataW-1:0] pop_data,
  output logic [1:0]       occupancy
);

  logic [DataW-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             pop;

  assign pop_valid = cnt_q != 2'd0;
  assign pop_data  = head_q;
  assign occupancy = cnt_q;
  assign pop       = pop_valid & pop_ready;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case ({push_valid, pop})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = push_data;
        else               tail_d = push_data;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        // Occupancy holds; the new beat lands behind whatever remains.
        if (cnt_q == 2'd1) begin
          head_d = push_data;
        end else begin
          head_d = tail_q;
          tail_d = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/mm_axis_seq_ctrl.sv
// Loads input/weight BRAMs from MM2S streams, runs the core, then streams results to S2MM.
module mm_axis_seq_ctrl
  import mm_axis_pkg::*;
#(
  parameter int unsigned WIDTH          = DefWidth,
  parameter int unsigned CHUNK_SIZE     = DefChunkSize,
  parameter int unsigned NUM_CORES      = DefNumCores,
  parameter int unsigned NUM_I_ELEMENTS = 4,
  parameter int unsigned NUM_W_ELEMENTS = 6,
  parameter int unsigned NUM_O_ELEMENTS = 6,
  parameter int unsigned IN_ADDR_W      = 2,
  parameter int unsigned WB_ADDR_W      = 3,
  parameter int unsigned OUT_ADDR_W     = 3
) (
  input  logic                                  aclk,
  input  logic                                  aresetn,
  input  logic                                  mm2s_i_tvalid,
  output logic                                  mm2s_i_tready,
  input  logic [WIDTH*CHUNK_SIZE*NUM_CORES-1:0] mm2s_i_tdata,
  input  logic                                  mm2s_w_tvalid,
  output logic                                  mm2s_w_tready,
  input  logic [WIDTH*CHUNK_SIZE-1:0]           mm2s_w_tdata,
  output logic                                  in_ena,
  output logic [WeWidth-1:0]                    in_wea,
  output logic [IN_ADDR_W-1:0]                  in_addra,
  output logic [WIDTH*CHUNK_SIZE*NUM_CORES-1:0] in_dina,
  output logic                                  wb_ena,
  output logic [WeWidth-1:0]                    wb_wea,
  output logic [WB_ADDR_W-1:0]                  wb_addra,
  output logic [WIDTH*CHUNK_SIZE-1:0]           wb_dina,
  output logic                                  top_start,
  input  logic                                  top_done,
  output logic                                  out_enb,
  output logic [OUT_ADDR_W-1:0]                 out_addrb,
  input  logic [WIDTH*CHUNK_SIZE*NUM_CORES-1:0] out_doutb,
  output logic                                  s2mm_tvalid,
  input  logic                                  s2mm_tready,
  output logic [WIDTH*CHUNK_SIZE*NUM_CORES-1:0] s2mm_tdata,
  output logic                                  s2mm_tlast,
  output logic                                  busy,
  output logic                                  job_done
);

  localparam int unsigned BeatW = beat_width(WIDTH, CHUNK_SIZE, NUM_CORES);
  localparam int unsigned ICntW = $clog2(NUM_I_ELEMENTS + 1);
  localparam int unsigned WCntW = $clog2(NUM_W_ELEMENTS + 1);
  localparam int unsigned OCntW = $clog2(NUM_O_ELEMENTS + 1);
  localparam logic [ICntW-1:0] IEnd  = ICntW'(NUM_I_ELEMENTS);
  localparam logic [WCntW-1:0] WEnd  = WCntW'(NUM_W_ELEMENTS);
  localparam logic [OCntW-1:0] OEnd  = OCntW'(NUM_O_ELEMENTS);
  localparam logic [OCntW-1:0] OLast = OCntW'(NUM_O_ELEMENTS - 1);

  state_e           state_q, state_d;
  logic [ICntW-1:0] i_cnt_q, i_cnt_d;
  logic [WCntW-1:0] w_cnt_q, w_cnt_d;
  logic [OCntW-1:0] rd_ptr_q, rd_ptr_d, beat_q, beat_d;
  logic             inflight_q;
  logic             i_hs, w_hs, rd_issue, pop, last_beat;
  logic [1:0]       occupancy;
  logic [2:0]       pending, allowance;

  assign mm2s_i_tready = (state_q == StLoad) && (i_cnt_q < IEnd);
  assign mm2s_w_tready = (state_q == StLoad) && (w_cnt_q < WEnd);
  assign i_hs          = mm2s_i_tready & mm2s_i_tvalid;
  assign w_hs          = mm2s_w_tready & mm2s_w_tvalid;

  assign in_ena   = i_hs;
  assign in_wea   = {WeWidth{i_hs}};
  assign in_addra = i_hs ? IN_ADDR_W'(i_cnt_q) : '0;
  assign in_dina  = i_hs ? mm2s_i_tdata : '0;
  assign wb_ena   = w_hs;
  assign wb_wea   = {WeWidth{w_hs}};
  assign wb_addra = w_hs ? WB_ADDR_W'(w_cnt_q) : '0;
  assign wb_dina  = w_hs ? mm2s_w_tdata : '0;

  assign pop       = s2mm_tvalid & s2mm_tready;
  // A beat leaving this cycle frees its slot before the read issued now arrives.
  assign pending   = {1'b0, occupancy} + {2'b00, inflight_q};
  assign allowance = 3'd2 + {2'b00, pop};
  assign rd_issue  = (state_q == StDrain) && (rd_ptr_q < OEnd) && (pending < allowance);
  assign out_enb   = rd_issue;
  assign out_addrb = rd_issue ? OUT_ADDR_W'(rd_ptr_q) : '0;

  assign last_beat  = beat_q == OLast;
  assign s2mm_tlast = s2mm_tvalid & last_beat;
  assign job_done   = (state_q == StDrain) & pop & last_beat;
  assign top_start  = state_q == StStart;
  assign busy       = state_q != StIdle;

  axis_skid2 #(
    .DataW(BeatW)
  ) u_skid (
    .clk       (aclk),
    .rst_n     (aresetn),
    .push_valid(inflight_q),
    .push_data (out_doutb),
    .pop_ready (s2mm_tready),
    .pop_valid (s2mm_tvalid),
    .pop_data  (s2mm_tdata),
    .occupancy (occupancy)
  );

  always_comb begin
    state_d  = state_q;
    i_cnt_d  = i_cnt_q;
    w_cnt_d  = w_cnt_q;
    rd_ptr_d = rd_ptr_q;
    beat_d   = beat_q;
    case (state_q)
      StIdle: begin
        if (mm2s_i_tvalid || mm2s_w_tvalid) state_d = StLoad;
      end
      StLoad: begin
        if (i_hs) i_cnt_d = i_cnt_q + ICntW'(1);
        if (w_hs) w_cnt_d = w_cnt_q + WCntW'(1);
        if ((i_cnt_q == IEnd) && (w_cnt_q == WEnd)) state_d = StStart;
      end
      StStart: begin
        i_cnt_d  = '0;
        w_cnt_d  = '0;
        rd_ptr_d = '0;
        beat_d   = '0;
        state_d  = StCompute;
      end
      StCompute: begin
        if (top_done) state_d = StDrain;
      end
      StDrain: begin
        if (rd_issue) rd_ptr_d = rd_ptr_q + OCntW'(1);
        if (pop)      beat_d   = beat_q + OCntW'(1);
        if (pop && last_beat) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= StIdle;
      i_cnt_q    <= '0;
      w_cnt_q    <= '0;
      rd_ptr_q   <= '0;
      beat_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_cnt_q    <= i_cnt_d;
      w_cnt_q    <= w_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      beat_q     <= beat_d;
      inflight_q <= rd_issue;
    end
  end

endmodule

// File: tb/tb_mm_axis_seq_ctrl.sv
// Randomized bench for mm_axis_seq_ctrl against a phase-level model of the job sequence.
module tb_mm_axis_seq_ctrl;

  localparam int BW = 128;
  localparam int WW = 64;
  localparam int NI = 4;
  localparam int NW = 6;
  localparam int NO = 6;
  localparam int PH_IDLE = 0, PH_LOAD = 1, PH_START = 2, PH_COMPUTE = 3, PH_DRAIN = 4;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          mm2s_i_tvalid = 1'b0, mm2s_i_tready;
  logic [BW-1:0] mm2s_i_tdata = '0;
  logic          mm2s_w_tvalid = 1'b0, mm2s_w_tready;
  logic [WW-1:0] mm2s_w_tdata = '0;
  logic          in_ena, wb_ena, top_start, out_enb, s2mm_tvalid, s2mm_tlast, busy, job_done;
  logic [7:0]    in_wea, wb_wea;
  logic [1:0]    in_addra;
  logic [2:0]    wb_addra, out_addrb;
  logic [BW-1:0] in_dina, s2mm_tdata;
  logic [WW-1:0] wb_dina;
  logic          top_done = 1'b0;
  logic [BW-1:0] out_doutb = '0;
  logic          s2mm_tready = 1'b0;

  always #5 aclk = ~aclk;

  mm_axis_seq_ctrl dut (
    .aclk(aclk), .aresetn(aresetn),
    .mm2s_i_tvalid(mm2s_i_tvalid), .mm2s_i_tready(mm2s_i_tready), .mm2s_i_tdata(mm2s_i_tdata),
    .mm2s_w_tvalid(mm2s_w_tvalid), .mm2s_w_tready(mm2s_w_tready), .mm2s_w_tdata(mm2s_w_tdata),
    .in_ena(in_ena), .in_wea(in_wea), .in_addra(in_addra), .in_dina(in_dina),
    .wb_ena(wb_ena), .wb_wea(wb_wea), .wb_addra(wb_addra), .wb_dina(wb_dina),
    .top_start(top_start), .top_done(top_done),
    .out_enb(out_enb), .out_addrb(out_addrb), .out_doutb(out_doutb),
    .s2mm_tvalid(s2mm_tvalid), .s2mm_tready(s2mm_tready), .s2mm_tdata(s2mm_tdata),
    .s2mm_tlast(s2mm_tlast), .busy(busy), .job_done(job_done)
  );

  int n_cmp = 0, n_bad = 0;
  int jn = -1;

  function automatic logic [BW-1:0] obeat(input int j, input int a);
    logic [31:0] w;
    w = 32'hC0DE0000 + 32'(j * 16 + a);
    return {4{w}};
  endfunction

  // Output BRAM: one-cycle read latency
  always @(posedge aclk) if (out_enb) out_doutb <= obeat(jn, int'(out_addrb));

  function automatic void check(input string name, input logic [BW-1:0] act,
                                input logic [BW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Model state and stimulus configuration
  int ph = PH_IDLE, mi = 0, mw = 0, mo = 0, mr = 0, dc = 0, cc = 0, jc = 0, tc = 0;
  bit prev_stall = 0, job_end = 0, iv = 0, wv = 0;
  logic [BW-1:0] prev_data = '0;
  logic [BW-1:0] iq[$];
  logic [WW-1:0] wq[$];
  int gap_i, gap_w, w_delay, done_delay, ready_mode, rst_after = -1;
  bit done_in_start;
  int starts, beats, tlasts, in_w, wb_w;
  logic [BW-1:0] first_in_data;
  logic [WW-1:0] last_wb_data;
  logic [2:0] first_in_addr, last_wb_addr;

  function automatic logic [BW-1:0] rnd_beat();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic cfg(input int gi, input int gw, input int wd, input int dd, input int rm,
                     input bit dis);
    gap_i = gi; gap_w = gw; w_delay = wd; done_delay = dd; ready_mode = rm; done_in_start = dis;
  endtask

  task automatic cycle();
    bit exp_ir, exp_wr, ihs, whs, epop;
    @(negedge aclk);
    if (!iv) iv = (iq.size() > 0) && ($urandom_range(0, 99) >= gap_i);
    if (!wv) wv = (wq.size() > 0) && (jc >= w_delay) && ($urandom_range(0, 99) >= gap_w);
    mm2s_i_tvalid = iv;
    mm2s_w_tvalid = wv;
    if (iv) mm2s_i_tdata = iq[0]; else mm2s_i_tdata = '0;
    if (wv) mm2s_w_tdata = wq[0]; else mm2s_w_tdata = '0;
    case (ready_mode)
      0:       s2mm_tready = 1'b1;
      1:       s2mm_tready = (tc % 4 == 0) || (tc % 4 == 3);
      default: s2mm_tready = $urandom_range(0, 2) != 0;
    endcase
    top_done = (ph == PH_START && done_in_start) || (ph == PH_COMPUTE && cc == done_delay);
    #1;
    exp_ir = (ph == PH_LOAD) && (mi < NI);
    exp_wr = (ph == PH_LOAD) && (mw < NW);
    ihs = exp_ir && iv;
    whs = exp_wr && wv;
    check("i_tready", BW'(mm2s_i_tready), BW'(exp_ir));
    check("w_tready", BW'(mm2s_w_tready), BW'(exp_wr));
    check("in_ena", BW'(in_ena), BW'(ihs));
    check("wb_ena", BW'(wb_ena), BW'(whs));
    if (ihs) begin
      check("in_wea", BW'(in_wea), BW'(8'hFF));
      check("in_addra", BW'(in_addra), BW'(mi));
      check("in_dina", in_dina, iq[0]);
    end
    if (whs) begin
      check("wb_wea", BW'(wb_wea), BW'(8'hFF));
      check("wb_addra", BW'(wb_addra), BW'(mw));
      check("wb_dina", BW'(wb_dina), BW'(wq[0]));
    end
    check("top_start", BW'(top_start), BW'(ph == PH_START));
    check("busy", BW'(busy), BW'(ph != PH_IDLE));
    epop = (ph == PH_DRAIN) && s2mm_tvalid && s2mm_tready;
    if (ph == PH_DRAIN) begin
      if (dc < 2) check("tvalid_early", BW'(s2mm_tvalid), BW'(0));
      if (dc == 2 || (ready_mode == 0 && dc >= 2 && dc <= 7))
        check("tvalid_rate", BW'(s2mm_tvalid), BW'(1));
      if (prev_stall) begin
        check("stall_valid", BW'(s2mm_tvalid), BW'(1));
        check("stall_data", s2mm_tdata, prev_data);
      end
      if (s2mm_tvalid) begin
        check("tdata", s2mm_tdata, obeat(jn, mo));
        check("tlast", BW'(s2mm_tlast), BW'(mo == NO - 1));
      end else begin
        check("tlast_idle", BW'(s2mm_tlast), BW'(0));
      end
      if (out_enb) begin
        check("out_addrb", BW'(out_addrb), BW'(mr));
        check("rd_bound", BW'(mr < NO), BW'(1));
      end
    end else begin
      check("tvalid_off", BW'(s2mm_tvalid), BW'(0));
      check("out_enb_off", BW'(out_enb), BW'(0));
    end
    check("job_done", BW'(job_done), BW'(epop && mo == NO - 1));

    if (ihs) begin
      if (in_w == 0) begin first_in_data = in_dina; first_in_addr = 3'(in_addra); end
      in_w++;
      void'(iq.pop_front());
      iv = 0;
    end
    if (whs) begin
      last_wb_addr = wb_addra;
      last_wb_data = wb_dina;
      wb_w++;
      void'(wq.pop_front());
      wv = 0;
    end
    if (top_start) starts++;
    if (epop) begin beats++; if (s2mm_tlast) tlasts++; end
    prev_stall = (ph == PH_DRAIN) && s2mm_tvalid && !s2mm_tready;
    prev_data  = s2mm_tdata;
    case (ph)
      PH_IDLE: if (iv || wv) ph = PH_LOAD;
      PH_LOAD: begin
        if (mi == NI && mw == NW) ph = PH_START;
        if (ihs) mi++;
        if (whs) mw++;
      end
      PH_START: begin ph = PH_COMPUTE; mi = 0; mw = 0; cc = 0; end
      PH_COMPUTE: begin
        if (top_done) begin ph = PH_DRAIN; dc = 0; mo = 0; mr = 0; prev_stall = 0; end
        else cc++;
      end
      default: begin
        dc++;
        if (out_enb) mr++;
        if (epop) begin
          if (mo == NO - 1) begin ph = PH_IDLE; job_end = 1; end
          mo++;
        end
      end
    endcase
    jc++;
    tc++;
  endtask

  task automatic check_quiet_outputs();
    check("rst_ctl", BW'({mm2s_i_tready, mm2s_w_tready, in_ena, wb_ena, top_start, out_enb,
                         s2mm_tvalid, s2mm_tlast, busy, job_done}), BW'(0));
    check("rst_wea", BW'({in_wea, wb_wea}), BW'(0));
    check("rst_addr", BW'({in_addra, wb_addra, out_addrb}), BW'(0));
    check("rst_in_dina", in_dina, '0);
    check("rst_wb_dina", BW'(wb_dina), BW'(0));
    check("rst_tdata", s2mm_tdata, '0);
  endtask

  task automatic do_reset();
    @(negedge aclk);
    s2mm_tready = 1'b1;
    top_done = 1'b0;
    aresetn = 1'b0;
    #1;
    check_quiet_outputs();
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      check("rst_hold", BW'({s2mm_tvalid, in_ena, wb_ena, out_enb}), BW'(0));
    end
    aresetn = 1'b1;
    mm2s_i_tvalid = 1'b0;
    mm2s_w_tvalid = 1'b0;
    ph = PH_IDLE; mi = 0; mw = 0; mo = 0; mr = 0; dc = 0; cc = 0;
    prev_stall = 0; iv = 0; wv = 0;
  endtask

  task automatic run_job();
    int n;
    jn++;
    n = 0; jc = 0; job_end = 0;
    starts = 0; beats = 0; tlasts = 0; in_w = 0; wb_w = 0;
    while (!job_end && n < 600) begin
      cycle();
      n++;
      if (rst_after >= 0 && ph == PH_DRAIN && mo == rst_after) begin
        rst_after = -1;
        do_reset();
        return;
      end
    end
    check("job_end", BW'(job_end), BW'(1));
    if (!job_end) do_reset();
  endtask

  task automatic push_job(input int n_in);
    for (int k = 0; k < n_in; k++) iq.push_back(rnd_beat());
    for (int k = 0; k < NW; k++) wq.push_back({$urandom, $urandom});
  endtask

  initial begin
    repeat (2) @(negedge aclk);
    check_quiet_outputs();
    aresetn = 1'b1;

    // Back-to-back full job with hand-known data
    cfg(0, 0, 0, 10, 0, 0);
    for (int k = 1; k <= NI; k++) iq.push_back(BW'(k));
    for (int k = 0; k < NW; k++) wq.push_back(WW'(64'hA + 64'(k)));
    run_job();
    check("j0_starts", BW'(starts), BW'(1));
    check("j0_beats", BW'(beats), BW'(6));
    check("j0_tlast", BW'(tlasts), BW'(1));
    check("j0_in_writes", BW'(in_w), BW'(4));
    check("j0_wb_writes", BW'(wb_w), BW'(6));
    check("j0_first_in", first_in_data, BW'(1));
    check("j0_last_wb_addr", BW'(last_wb_addr), BW'(5));
    check("j0_last_wb_data", BW'(last_wb_data), BW'(64'hF));

    // Weights arrive well after inputs, with valid gaps on both
    cfg(40, 30, 25, 3, 2, 0);
    push_job(NI);
    run_job();
    check("j1_in_writes", BW'(in_w), BW'(4));
    check("j1_wb_writes", BW'(wb_w), BW'(6));

    // Output backpressure 1,0,0,1
    cfg(0, 0, 0, 2, 1, 0);
    push_job(NI);
    run_job();
    check("j2_beats", BW'(beats), BW'(6));

    // Five input beats offered; the last waits for the following job
    cfg(0, 0, 0, 4, 0, 0);
    push_job(NI);
    iq.push_back(BW'(5));
    run_job();
    check("j3_in_writes", BW'(in_w), BW'(4));
    cfg(10, 10, 0, 4, 2, 0);
    push_job(NI - 1);
    run_job();
    check("j4_first_addr", BW'(first_in_addr), BW'(0));
    check("j4_first_in", first_in_data, BW'(5));

    // Reset after three output beats, then a clean job
    cfg(0, 0, 0, 6, 1, 0);
    rst_after = 3;
    push_job(NI);
    run_job();
    check("j5_beats_before_rst", BW'(beats), BW'(3));
    cfg(0, 0, 0, 6, 0, 0);
    push_job(NI);
    run_job();
    check("j6_first_addr", BW'(first_in_addr), BW'(0));
    check("j6_beats", BW'(beats), BW'(6));
    check("j6_tlast", BW'(tlasts), BW'(1));

    // top_done raised during START must be ignored
    cfg(0, 0, 0, 5, 0, 1);
    push_job(NI);
    run_job();
    check("j7_starts", BW'(starts), BW'(1));
    check("j7_beats", BW'(beats), BW'(6));

    for (int r = 0; r < 6; r++) begin
      cfg($urandom_range(0, 50), $urandom_range(0, 50), $urandom_range(0, 10),
          $urandom_range(0, 15), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      push_job(NI);
      run_job();
      check("jr_tlast", BW'(tlasts), BW'(1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
